// File: rtl/beatmap_sequencer.sv
// Beat-paced chart reader: walks the 4-lane note ROM one entry per beat and hands
// non-empty lane patterns to the note-spawn engine. Define SEQ_LOOP_EN to repeat the chart.
module beatmap_sequencer #(
  parameter int unsigned NUM_NOTES = 80,
  parameter int unsigned BEAT_DIV  = 12500000,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic              spawn_valid,
  output logic [3:0]        spawn_lanes,
  input  logic              spawn_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned       CNT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NOTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BEAT,
    S_FETCH,
    S_CAPTURE,
    S_SPAWN,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic              pending;

  logic              running;
  logic              start_ok;
  logic              tick;
  logic              beat_due;
  logic              last_entry;
  state_t            adv_state;
  logic [ADDR_W-1:0] adv_addr;
  logic              adv_busy;
  logic              adv_done;

  // Beat qualification and the shared "advance to next entry" decision.
  always_comb begin
    running    = (state != S_IDLE) && (state != S_DONE);
    start_ok   = start && !running;
    tick       = running && !pause && (beat_cnt == CNT_LAST);
    beat_due   = (state == S_WAIT_BEAT) && !pause && (pending || tick);
    last_entry = (rom_addr == LAST_IDX);
    adv_state  = S_WAIT_BEAT;
    adv_addr   = rom_addr + ADDR_W'(1);
    adv_busy   = 1'b1;
    adv_done   = 1'b0;
`ifdef SEQ_LOOP_EN
    if (last_entry) begin
      adv_addr = '0;
    end
`else
    if (last_entry) begin
      adv_state = S_DONE;
      adv_addr  = rom_addr;
      adv_busy  = 1'b0;
      adv_done  = 1'b1;
    end
`endif
  end

  // Beat timer runs in every busy state; a beat arriving while one is still
  // outstanding is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else if (start_ok) begin
      beat_cnt <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (running && !pause) begin
        beat_cnt <= tick ? '0 : beat_cnt + CNT_W'(1);
      end
      if (beat_due) begin
        pending <= 1'b0;
      end else if (tick) begin
        pending <= 1'b1;
      end
      if (tick && pending) begin
        overrun <= 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      spawn_valid <= 1'b0;
      spawn_lanes <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_WAIT_BEAT;
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_WAIT_BEAT: begin
          if (beat_due) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          spawn_lanes <= rom_data;
          if (rom_data == 4'b0000) begin
            state    <= adv_state;
            rom_addr <= adv_addr;
            busy     <= adv_busy;
            done     <= adv_done;
          end else begin
            state       <= S_SPAWN;
            spawn_valid <= 1'b1;
          end
        end
        S_SPAWN: begin
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            state       <= adv_state;
            rom_addr    <= adv_addr;
            busy        <= adv_busy;
            done        <= adv_done;
          end
        end
        default: begin
          state       <= S_IDLE;
          spawn_valid <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beatmap_sequencer.sv
// Self-checking bench for beatmap_sequencer: cycle-exact vector table for the first
// entries, then pause, mid-handshake reset, full chart and restart sequences.
module tb_beatmap_sequencer;

  localparam int unsigned NUM_NOTES = 80;
  localparam int unsigned BEAT_DIV  = 4;
  localparam int unsigned ADDR_W    = 13;
  localparam int          NROWS     = 29;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              spawn_ready = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data = 4'b0000;
  logic              spawn_valid;
  logic [3:0]        spawn_lanes;
  logic              busy;
  logic              done;
  logic              overrun;

  logic [3:0] rom [NUM_NOTES];

  beatmap_sequencer #(
    .NUM_NOTES(NUM_NOTES),
    .BEAT_DIV (BEAT_DIV),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .pause      (pause),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Registered-read note ROM model.
  always @(posedge clk) begin
    rom_data <= (rom_addr < ADDR_W'(NUM_NOTES)) ? rom[rom_addr[6:0]] : 4'b0000;
  end

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [3:0]        lanes;
  } sb_t;

  typedef struct packed {
    logic              start;
    logic              ready;
    logic              pause;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [3:0]        lanes;
    logic              busy;
    logic              done;
    logic              ovr;
  } vec_t;

  sb_t  sbq [$];
  vec_t vt [NROWS];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rdy, input int a, input int v, input int l, input int o);
    vec_t r;
    r       = '0;
    r.ready = rdy[0];
    r.addr  = ADDR_W'(a);
    r.valid = v[0];
    r.lanes = l[3:0];
    r.busy  = 1'b1;
    r.ovr   = o[0];
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({rom_addr, spawn_valid, spawn_lanes, busy, done, overrun});
  endfunction

  task automatic sb_load();
    sbq.delete();
    for (int i = 0; i < int'(NUM_NOTES); i++) begin
      if (rom[i] != 4'b0000) sbq.push_back({ADDR_W'(i), rom[i]});
    end
  endtask

  // Pops the expected pattern whenever the handshake completes this cycle.
  task automatic sb_check();
    sb_t e;
    if (resetn && spawn_valid && spawn_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: unexpected spawn idx %0d lanes %b", rom_addr, spawn_lanes);
      end else begin
        e = sbq.pop_front();
        check("sb_spawn", 32'({rom_addr, spawn_lanes}), 32'({e.idx, e.lanes}));
      end
    end
  endtask

  task automatic step();
    sb_check();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int first;
    int n0;
    bit seen;

    for (int i = 0; i < int'(NUM_NOTES); i++) begin
      rom[i] = (i % 4 == 3) ? 4'b0000 : 4'(i % 15 + 1);
    end
    rom[0] = 4'b1000;
    rom[1] = 4'b0000;
    rom[2] = 4'b0101;
    rom[3] = 4'b0011;

    // Cycle-by-cycle expectations after a start pulse in row 0.
    for (int k = 0; k <= 5; k++) vt[k] = mk(1, 0, 0, 4'b0000, 0);
    vt[0].start = 1'b1;
    vt[6] = mk(1, 0, 1, 4'b1000, 0);
    for (int k = 7; k <= 9; k++)   vt[k] = mk(1, 1, 0, 4'b1000, 0);
    for (int k = 10; k <= 11; k++) vt[k] = mk(1, 2, 0, 4'b0000, 0);
    for (int k = 12; k <= 13; k++) vt[k] = mk(0, 2, 0, 4'b0000, 0);
    for (int k = 14; k <= 23; k++) vt[k] = mk(0, 2, 1, 4'b0101, (k >= 20) ? 1 : 0);
    for (int k = 24; k <= 26; k++) vt[k] = mk(1, 3, 0, 4'b0101, 1);
    vt[27] = mk(1, 3, 1, 4'b0011, 1);
    vt[28] = mk(1, 4, 0, 4'b0011, 1);

    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_addr", 32'(rom_addr), 32'(0));
    check("rst_valid", 32'(spawn_valid), 32'(0));
    check("rst_lanes", 32'(spawn_lanes), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    resetn = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'(0));

    sb_load();
    for (int k = 0; k < NROWS; k++) begin
      start       = vt[k].start;
      spawn_ready = vt[k].ready;
      pause       = vt[k].pause;
      step();
      check($sformatf("vec%0d", k), outs(),
            32'({vt[k].addr, vt[k].valid, vt[k].lanes, vt[k].busy, vt[k].done, vt[k].ovr}));
    end
    start = 1'b0;

    // Reset in the middle of a stalled handshake.
    spawn_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = spawn_valid;
    end
    check("midspawn_valid_seen", 32'(seen), 32'(1));
    resetn = 1'b0;
    step();
    check("midspawn_rst", outs(), 32'(0));
    resetn = 1'b1;
    step();
    check("midspawn_idle", outs(), 32'(0));

    // Restart, then pause 20 cycles in WAIT_BEAT with the counter at 1.
    sb_load();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", 32'({rom_addr, busy}), 32'({ADDR_W'(0), 1'b1}));
    step();
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("pause_hold", 32'({rom_addr, spawn_valid, busy}), 32'({ADDR_W'(0), 1'b0, 1'b1}));
    end
    pause = 1'b0;
    spawn_ready = 1'b1;
    first = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (spawn_valid && first < 0) first = n;
    end
    check("pause_resume_latency", 32'(first), 32'(5));

    // start while busy must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;

    seen = 1'b0;
`ifdef SEQ_LOOP_EN
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      seen = (sbq.size() == 0);
    end
    check("loop_chart_done", 32'(seen), 32'(1));
    sb_load();
    n0 = sbq.size();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      seen = (sbq.size() == n0 - 1);
    end
    check("loop_repeat_entry0", 32'(seen), 32'(1));
    check("loop_no_done", 32'({busy, done, overrun}), 32'({1'b1, 1'b0, 1'b0}));
`else
    n0 = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      seen = done;
      if (!seen) n0 = int'(busy);
    end
    check("chart_done_seen", 32'(seen), 32'(1));
    check("chart_busy_before_done", 32'(n0), 32'(1));
    check("chart_end", outs(),
          32'({ADDR_W'(NUM_NOTES - 1), 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0}));
    check("chart_all_spawned", 32'(sbq.size()), 32'(0));
    for (int i = 0; i < 3; i++) step();
    check("done_hold", outs(),
          32'({ADDR_W'(NUM_NOTES - 1), 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0}));
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_restart", 32'({rom_addr, busy, done}), 32'({ADDR_W'(0), 1'b1, 1'b0}));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
